branch_unit: RTL and testbench

Branch/jump resolution block that drives the program counter's `branch_en` and `target` inputs. Each cycle it decodes the current instruction's control-flow operation, evaluates the registered condition flag, looks up absolute targets in a writable target table, and manages a return-address stack for CALL/RET. It sits between the decoder/ALU and the program counter. It keeps a saturating count of taken control transfers for performance checks.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_unit_ret_stack.sv | 55 +++++
 rtl/branch_unit.sv | 129 ++++++++++++
 tb/tb_branch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================
// branch_pkg : shared widths and control-op encoding
// Revision   : 1.0
// ============================================================
package branch_pkg;
   localparam int c_PC_W  = 12;
   localparam int c_LUT_N = 16;
   localparam int c_RAS_D = 4;

   typedef enum logic [2:0] {
      NONE = 3'd0,
      JMP  = 3'd1,
      BZ   = 3'd2,
      BNZ  = 3'd3,
      CALL = 3'd4,
      RET  = 3'd5
   } br_op_t;
endpackage
`default_nettype wire

// File: rtl/branch_unit_ret_stack.sv
`default_nettype none
// ============================================================
// ret_stack : circular return-address stack, overwrites oldest
// Revision  : 1.0
// ============================================================
module ret_stack
   import branch_pkg::*;
#(
   parameter int DEPTH = c_RAS_D,
   parameter int W     = c_PC_W
) (
   input  logic         CLK,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);
   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

   logic [W-1:0]       r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wp;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_PTR_W-1:0] w_wp_inc;
   logic [c_PTR_W-1:0] w_wp_dec;

   // r_wp is the next free slot; the newest entry sits just below it
   assign w_wp_inc = (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
   assign w_wp_dec = (r_wp == '0) ? c_LAST : r_wp - 1'b1;
   assign top      = r_mem[w_wp_dec];
   assign empty    = (r_cnt == '0);
   assign full     = (r_cnt == c_CNT_W'(DEPTH));

   always_ff @(posedge CLK) begin
      if (rst) begin
         r_wp  <= '0;
         r_cnt <= '0;
      end else if (push) begin
         r_wp <= w_wp_inc;
         if (!full) r_cnt <= r_cnt + 1'b1;
      end else if (pop && !empty) begin
         r_wp  <= w_wp_dec;
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) r_mem[r_wp] <= push_data;
   end
endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// ============================================================
// branch_unit : branch/jump resolution with target table and RAS
// Revision    : 1.0
// ============================================================
module branch_unit
   import branch_pkg::*;
#(
   parameter int PC_W  = c_PC_W,
   parameter int LUT_N = c_LUT_N,
   parameter int RAS_D = c_RAS_D
) (
   input  logic                     CLK,
   input  logic                     init,
   input  logic                     halt,
   input  logic [PC_W-1:0]          pc,
   input  logic [2:0]               br_op,
   input  logic [$clog2(LUT_N)-1:0] lut_idx,
   input  logic                     flag_we,
   input  logic                     zero_in,
   input  logic                     lut_we,
   input  logic [$clog2(LUT_N)-1:0] lut_waddr,
   input  logic [PC_W-1:0]          lut_wdata,
   output logic                     branch_en,
   output logic [PC_W-1:0]          target,
   output logic                     ras_ovf,
   output logic                     ras_unf,
   output logic [15:0]              taken_cnt
);
   logic [PC_W-1:0] r_lut [LUT_N];
   logic            r_zf;
   logic            r_ovf;
   logic            r_unf;
   logic [15:0]     r_taken_cnt;

   br_op_t          w_op;
   logic [PC_W-1:0] w_lut_rd;
   logic [PC_W-1:0] w_ras_top;
   logic            w_ras_empty;
   logic            w_ras_full;
   logic            w_taken;
   logic [PC_W-1:0] w_target;
   logic            w_push;
   logic            w_pop;
   logic            w_unf_set;

   assign w_op     = br_op_t'(br_op);
   assign w_lut_rd = r_lut[lut_idx];

   // init and halt both suppress every state-changing decision here
   always_comb begin
      w_taken   = 1'b0;
      w_target  = '0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_unf_set = 1'b0;
      if (!init && !halt) begin
         case (w_op)
            JMP: begin
               w_taken  = 1'b1;
               w_target = w_lut_rd;
            end
            BZ: if (r_zf) begin
               w_taken  = 1'b1;
               w_target = w_lut_rd;
            end
            BNZ: if (!r_zf) begin
               w_taken  = 1'b1;
               w_target = w_lut_rd;
            end
            CALL: begin
               w_taken  = 1'b1;
               w_target = w_lut_rd;
               w_push   = 1'b1;
            end
            RET: begin
               if (!w_ras_empty) begin
                  w_taken  = 1'b1;
                  w_target = w_ras_top;
                  w_pop    = 1'b1;
               end else begin
                  w_unf_set = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   ret_stack #(
      .DEPTH (RAS_D),
      .W     (PC_W)
   ) u_ret_stack (
      .CLK       (CLK),
      .rst       (init),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (pc + PC_W'(1)),
      .top       (w_ras_top),
      .empty     (w_ras_empty),
      .full      (w_ras_full)
   );

   always_ff @(posedge CLK) begin
      if (init) begin
         r_zf        <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_taken_cnt <= '0;
      end else if (!halt) begin
         if (flag_we) r_zf <= zero_in;
         if (w_push && w_ras_full) r_ovf <= 1'b1;
         if (w_unf_set) r_unf <= 1'b1;
         if (w_taken && (r_taken_cnt != 16'hFFFF)) r_taken_cnt <= r_taken_cnt + 16'd1;
      end
   end

   // table is not reset and stays writable through init and halt
   always_ff @(posedge CLK) begin
      if (lut_we) r_lut[lut_waddr] <= lut_wdata;
   end

   assign branch_en = w_taken;
   assign target    = w_target;
   assign ras_ovf   = r_ovf;
   assign ras_unf   = r_unf;
   assign taken_cnt = r_taken_cnt;
endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// ============================================================
// tb_branch_unit : directed vector table plus randomized model checks
// Revision       : 1.0
// ============================================================
module tb_branch_unit;
   localparam int RAS_D = 4;

   logic        CLK = 1'b0;
   logic        init, halt, flag_we, zero_in, lut_we;
   logic [11:0] pc, lut_wdata;
   logic [2:0]  br_op;
   logic [3:0]  lut_idx, lut_waddr;
   logic        branch_en, ras_ovf, ras_unf;
   logic [11:0] target;
   logic [15:0] taken_cnt;

   always #5 CLK = ~CLK;

   branch_unit dut (
      .CLK       (CLK),
      .init      (init),
      .halt      (halt),
      .pc        (pc),
      .br_op     (br_op),
      .lut_idx   (lut_idx),
      .flag_we   (flag_we),
      .zero_in   (zero_in),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata),
      .branch_en (branch_en),
      .target    (target),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf),
      .taken_cnt (taken_cnt)
   );

   typedef struct {
      bit          init, halt;
      logic [11:0] pc;
      logic [2:0]  op;
      logic [3:0]  idx;
      bit          fwe, zin, lwe;
      logic [3:0]  waddr;
      logic [11:0] wdata;
      bit          e_en;
      logic [11:0] e_tgt;
   } vec_t;

   // reference state: plain variables and a queue used as the stack
   bit          m_zf, m_ovf, m_unf;
   logic [11:0] m_lut [16];
   logic [11:0] m_ras [$];
   int          m_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   function automatic vec_t mk(bit i_, bit h_, int pc_, int op_, int idx_, bit fwe_, bit zin_,
                               bit lwe_, int wa_, int wd_, bit een_, int etgt_);
      vec_t v;
      v.init = i_;  v.halt = h_;  v.pc = 12'(pc_);  v.op = 3'(op_);  v.idx = 4'(idx_);
      v.fwe = fwe_; v.zin = zin_; v.lwe = lwe_;     v.waddr = 4'(wa_); v.wdata = 12'(wd_);
      v.e_en = een_; v.e_tgt = 12'(etgt_);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic void model_comb(output bit en, output logic [11:0] t);
      en = 1'b0;
      t  = '0;
      if (!init && !halt) begin
         case (br_op)
            3'd1, 3'd4: begin en = 1'b1; t = m_lut[lut_idx]; end
            3'd2: if (m_zf)  begin en = 1'b1; t = m_lut[lut_idx]; end
            3'd3: if (!m_zf) begin en = 1'b1; t = m_lut[lut_idx]; end
            3'd5: if (m_ras.size() > 0) begin en = 1'b1; t = m_ras[$]; end
            default: ;
         endcase
      end
   endfunction

   task automatic model_edge(input bit en);
      logic [11:0] ret_addr;
      if (init) begin
         m_zf = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_cnt = 0;
         m_ras.delete();
      end else if (!halt) begin
         if (flag_we) m_zf = zero_in;
         if (en && m_cnt < 65535) m_cnt++;
         if (br_op == 3'd4) begin
            if (m_ras.size() == RAS_D) begin
               void'(m_ras.pop_front());
               m_ovf = 1'b1;
            end
            ret_addr = pc + 12'd1;
            m_ras.push_back(ret_addr);
         end
         if (br_op == 3'd5) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_unf = 1'b1;
         end
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
   endtask

   task automatic apply(input vec_t v, input bit use_exp);
      bit          e_en;
      logic [11:0] e_t;
      init = v.init; halt = v.halt; pc = v.pc; br_op = v.op; lut_idx = v.idx;
      flag_we = v.fwe; zero_in = v.zin; lut_we = v.lwe; lut_waddr = v.waddr; lut_wdata = v.wdata;
      #1;
      model_comb(e_en, e_t);
      chk("branch_en", 32'(branch_en), 32'(e_en));
      chk("target",    32'(target),    32'(e_t));
      chk("ras_ovf",   32'(ras_ovf),   32'(m_ovf));
      chk("ras_unf",   32'(ras_unf),   32'(m_unf));
      chk("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
      if (use_exp) begin
         chk("vec_branch_en", 32'(branch_en), 32'(v.e_en));
         chk("vec_target",    32'(target),    32'(v.e_tgt));
      end
      @(posedge CLK);
      model_edge(e_en);
      @(negedge CLK);
   endtask

   vec_t tv [$];

   initial begin
      m_zf = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_cnt = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = '0;
      init = 1'b1; halt = 1'b0; pc = '0; br_op = 3'd1; lut_idx = '0;
      flag_we = 1'b0; zero_in = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
      @(negedge CLK);

      // preload the whole table while held in init
      for (int i = 0; i < 16; i++)
         apply(mk(1, 0, 0, 1, i, 0, 0, 1, i, 12'h800 | i, 0, 0), 1'b1);

      //          init halt pc     op idx fwe zin lwe wa  wd      en tgt
      tv.push_back(mk(1, 0, 0,      1, 0,  0,  0,  0,  0, 0,      0, 0));
      tv.push_back(mk(1, 0, 0,      1, 0,  0,  0,  0,  0, 0,      0, 0));
      tv.push_back(mk(0, 0, 0,      1, 3,  0,  0,  1,  3, 12'h0A5, 1, 12'h803));
      tv.push_back(mk(0, 0, 1,      1, 3,  0,  0,  0,  0, 0,      1, 12'h0A5));
      tv.push_back(mk(0, 0, 2,      2, 5,  1,  1,  0,  0, 0,      0, 0));
      tv.push_back(mk(0, 0, 3,      2, 5,  0,  0,  0,  0, 0,      1, 12'h805));
      tv.push_back(mk(0, 0, 4,      3, 6,  0,  0,  0,  0, 0,      0, 0));
      tv.push_back(mk(0, 0, 10,     4, 7,  0,  0,  0,  0, 0,      1, 12'h807));
      tv.push_back(mk(0, 0, 20,     4, 8,  0,  0,  0,  0, 0,      1, 12'h808));
      tv.push_back(mk(0, 0, 30,     4, 9,  0,  0,  0,  0, 0,      1, 12'h809));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      1, 31));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      1, 21));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      1, 11));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      0, 0));
      tv.push_back(mk(0, 0, 0,      0, 0,  0,  0,  0,  0, 0,      0, 0));
      tv.push_back(mk(0, 0, 0,      6, 1,  0,  0,  0,  0, 0,      0, 0));
      // overflow: five calls into a four-deep stack
      tv.push_back(mk(1, 0, 0,      0, 0,  0,  0,  0,  0, 0,      0, 0));
      for (int p = 1; p <= 5; p++)
         tv.push_back(mk(0, 0, p,   4, 1,  0,  0,  0,  0, 0,      1, 12'h801));
      for (int r = 6; r >= 3; r--)
         tv.push_back(mk(0, 0, 0,   5, 0,  0,  0,  0,  0, 0,      1, r));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      0, 0));
      // halt freezes the stack, init clears it even under halt
      tv.push_back(mk(0, 0, 12'h50, 4, 2,  0,  0,  0,  0, 0,      1, 12'h802));
      tv.push_back(mk(0, 1, 100,    4, 2,  1,  1,  0,  0, 0,      0, 0));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      1, 12'h051));
      tv.push_back(mk(0, 0, 7,      4, 2,  0,  0,  0,  0, 0,      1, 12'h802));
      tv.push_back(mk(1, 1, 9,      4, 2,  0,  0,  0,  0, 0,      0, 0));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      0, 0));
      // return address wraps at the top of the address space
      tv.push_back(mk(0, 0, 12'hFFF,4, 4,  0,  0,  0,  0, 0,      1, 12'h804));
      tv.push_back(mk(0, 0, 0,      5, 0,  0,  0,  0,  0, 0,      1, 12'h000));

      foreach (tv[k]) apply(tv[k], 1'b1);

      for (int n = 0; n < 600; n++) begin
         apply(mk($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
                  1'($urandom), $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4095)), 0, 0), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
